innings_scorer: RTL and testbench
=================================

Name: innings_scorer

Overview:
- Upstream scoring stage. Converts per-delivery outcome events into the per-team run/wicket/ball totals consumed by the score comparator.
- Tracks which team is batting with a small state machine driven by the comparator's inningOver and gameOver.
- Locks each innings at the ball/wicket limits locally, so deliveries arriving in the comparator's one-cycle decision latency are not mis-credited.

Parameters:
- MAX_BALLS, 20, legal deliveries per innings.
- MAX_WICKETS, 5, wickets per innings.

Ports:
- clk_fpga  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- ball_valid  in  1  one-cycle strobe; ball_code is valid this cycle.
- ball_code  in  4  delivery outcome:
  - 0-6: legal ball, that many runs.
  - 7: wicket, legal ball, 0 runs.
  - 8: wide, 1 run, not a legal ball.
  - 9: no-ball, 1 run, not a legal ball.
  - 10-15: illegal code.
- inningOver  in  1  from comparator; first innings finished.
- gameOver  in  1  from comparator; match finished.
- team1Data  out  12  [11:4] team 1 runs, [3:0] team 1 wickets.
- team2Data  out  12  [11:4] team 2 runs, [3:0] team 2 wickets.
- team1Balls  out  8  team 1 legal balls.
- team2Balls  out  8  team 2 legal balls.
- balls  out  8  legal balls of the currently batting team (0 in DONE).
- batting_team  out  1  0 = team 1, 1 = team 2.
- ball_drop  out  1  one-cycle pulse when a strobed event is discarded.

Behaviour:
- Reset (asynchronous assert, synchronous release to clk_fpga):
  - All counters 0; state = TEAM1; batting_team = 0; ball_drop = 0.
- All outputs are registered. A delivery sampled at edge N is visible in the totals after edge N; latency is 1 cycle.
- States:
  - TEAM1: scores team 1. inningOver = 1 -> BREAK. gameOver = 1 -> DONE (gameOver has priority).
  - BREAK: exactly one cycle; all events are dropped; batting_team becomes 1 on exit. Next state is TEAM2, or DONE if gameOver = 1.
  - TEAM2: scores team 2. gameOver = 1 -> DONE.
  - DONE: terminal; all events are dropped; totals frozen; leaves only on reset.
- Innings lock:
  - A team is locked when its wickets >= MAX_WICKETS or its legal balls >= MAX_BALLS.
  - A strobe arriving while the batting team is locked is dropped, even before inningOver rises.
- Update rules for an accepted event on the batting team:
  - Code 0-6: runs += code; legal balls += 1.
  - Code 7: wickets += 1; legal balls += 1.
  - Code 8 or 9: runs += 1; legal balls unchanged.
  - Runs saturate at 255 and never wrap. Wickets cannot exceed MAX_WICKETS because of the lock. Ball counters cannot exceed MAX_BALLS.
- ball_drop is asserted for one cycle, on the edge after the strobe, when any of these hold:
  - ball_code >= 10 (no counter changes);
  - the batting team is locked;
  - state is BREAK or DONE.
- Simultaneous events:
  - ball_valid together with inningOver in TEAM1: the ball is applied to team 1 if team 1 is unlocked; the state still moves to BREAK.
  - ball_valid together with gameOver in TEAM2: the ball is applied if team 2 is unlocked; the state moves to DONE on the same edge.
- The non-batting team's totals never change while the other team bats.
- Reset mid-innings clears everything immediately, without waiting for a clock edge.
- balls tracks team1Balls in TEAM1, team2Balls in TEAM2, and reads 0 in BREAK and DONE.

Test Plan:
- Reset, then codes 4, 6, 8, 1 strobed on consecutive cycles -> team1Data runs = 12, wickets = 0; team1Balls = 3; balls = 3; ball_drop never set.
- Five code-7 strobes, then a code-4 strobe before inningOver is driven -> team1Data wickets = 5; team1Balls = 5; runs unchanged; ball_drop pulses once for the code-4 event.
- Drive inningOver = 1 with a code-2 strobe in the BREAK cycle -> the strobe is dropped; batting_team = 1 after BREAK; a following code-3 gives team2Data runs = 3 and team2Balls = 1; team 1 totals are unchanged.
- 20 legal balls for team 2, then a code-9 strobe -> team2Balls = 20 and the no-ball is dropped. Drive gameOver -> state DONE; later strobes all pulse ball_drop; balls = 0.
- Feed 43 code-6 strobes with MAX_BALLS overridden to 64 -> team 1 runs saturate at 255, not 2.
- Assert reset asynchronously mid-clock during TEAM2 with non-zero totals -> all outputs read 0 and batting_team = 0 before the next clock edge; scoring then resumes in TEAM1.

Source files
------------

// File: rtl/innings_scorer.sv
// rtl/innings_scorer.sv - per-delivery run/wicket/ball accumulator with batting-team state machine
module innings_scorer #(
  parameter int MAX_BALLS   = 20,
  parameter int MAX_WICKETS = 5
) (
  input  logic        clk_fpga,
  input  logic        reset,
  input  logic        ball_valid,
  input  logic [3:0]  ball_code,
  input  logic        inningOver,
  input  logic        gameOver,
  output logic [11:0] team1Data,
  output logic [11:0] team2Data,
  output logic [7:0]  team1Balls,
  output logic [7:0]  team2Balls,
  output logic [7:0]  balls,
  output logic        batting_team,
  output logic        ball_drop
);

  typedef enum logic [1:0] {
    S_TEAM1 = 2'd0,
    S_BREAK = 2'd1,
    S_TEAM2 = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] MAX_B = 8'(MAX_BALLS);
  localparam logic [3:0] MAX_W = 4'(MAX_WICKETS);

  state_e     state_q, state_d;
  logic [7:0] runs1_q, runs1_d;
  logic [3:0] wkts1_q, wkts1_d;
  logic [7:0] balls1_q, balls1_d;
  logic [7:0] runs2_q, runs2_d;
  logic [3:0] wkts2_q, wkts2_d;
  logic [7:0] balls2_q, balls2_d;
  logic [7:0] balls_q, balls_d;
  logic       bat_q, bat_d;
  logic       drop_q, drop_d;

  logic       code_illegal;
  logic       code_legal_ball;
  logic       code_wicket;
  logic [7:0] run_inc;
  logic       team1_locked;
  logic       team2_locked;
  logic       batting_locked;
  logic       scoring;
  logic       accept;

  // Runs never wrap; a large total pins at 255.
  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Decode the delivery code into run increment and ball/wicket flags.
  always_comb begin
    code_illegal    = (ball_code >= 4'd10);
    code_legal_ball = (ball_code <= 4'd7);
    code_wicket     = (ball_code == 4'd7);
    run_inc         = 8'd0;
    if (ball_code <= 4'd6) begin
      run_inc = {4'd0, ball_code};
    end else if (ball_code == 4'd8 || ball_code == 4'd9) begin
      run_inc = 8'd1;
    end
  end

  // Innings lock and accept/drop decision for the current strobe.
  always_comb begin
    team1_locked   = (wkts1_q >= MAX_W) || (balls1_q >= MAX_B);
    team2_locked   = (wkts2_q >= MAX_W) || (balls2_q >= MAX_B);
    scoring        = (state_q == S_TEAM1) || (state_q == S_TEAM2);
    batting_locked = 1'b1;
    if (state_q == S_TEAM1) begin
      batting_locked = team1_locked;
    end else if (state_q == S_TEAM2) begin
      batting_locked = team2_locked;
    end
    accept = ball_valid && scoring && !code_illegal && !batting_locked;
    drop_d = ball_valid && !accept;
  end

  // Apply an accepted delivery to whichever team is batting.
  always_comb begin
    runs1_d  = runs1_q;
    wkts1_d  = wkts1_q;
    balls1_d = balls1_q;
    runs2_d  = runs2_q;
    wkts2_d  = wkts2_q;
    balls2_d = balls2_q;
    if (accept && state_q == S_TEAM1) begin
      runs1_d = sat_add(runs1_q, run_inc);
      if (code_legal_ball) balls1_d = balls1_q + 8'd1;
      if (code_wicket)     wkts1_d  = wkts1_q + 4'd1;
    end else if (accept && state_q == S_TEAM2) begin
      runs2_d = sat_add(runs2_q, run_inc);
      if (code_legal_ball) balls2_d = balls2_q + 8'd1;
      if (code_wicket)     wkts2_d  = wkts2_q + 4'd1;
    end
  end

  // Innings sequencing; gameOver always wins over inningOver.
  always_comb begin
    state_d = state_q;
    bat_d   = bat_q;
    case (state_q)
      S_TEAM1: begin
        if (gameOver) begin
          state_d = S_DONE;
        end else if (inningOver) begin
          state_d = S_BREAK;
        end
      end
      S_BREAK: begin
        bat_d   = 1'b1;
        state_d = gameOver ? S_DONE : S_TEAM2;
      end
      S_TEAM2: begin
        if (gameOver) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_TEAM1;
      end
    endcase
  end

  // Current-batting ball count follows the state being entered, so it stays aligned with the totals.
  always_comb begin
    balls_d = 8'd0;
    if (state_d == S_TEAM1) begin
      balls_d = balls1_d;
    end else if (state_d == S_TEAM2) begin
      balls_d = balls2_d;
    end
  end

  // State and counter registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk_fpga or posedge reset) begin
    if (reset) begin
      state_q  <= S_TEAM1;
      runs1_q  <= 8'd0;
      wkts1_q  <= 4'd0;
      balls1_q <= 8'd0;
      runs2_q  <= 8'd0;
      wkts2_q  <= 4'd0;
      balls2_q <= 8'd0;
      balls_q  <= 8'd0;
      bat_q    <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      runs1_q  <= runs1_d;
      wkts1_q  <= wkts1_d;
      balls1_q <= balls1_d;
      runs2_q  <= runs2_d;
      wkts2_q  <= wkts2_d;
      balls2_q <= balls2_d;
      balls_q  <= balls_d;
      bat_q    <= bat_d;
      drop_q   <= drop_d;
    end
  end

  assign team1Data    = {runs1_q, wkts1_q};
  assign team2Data    = {runs2_q, wkts2_q};
  assign team1Balls   = balls1_q;
  assign team2Balls   = balls2_q;
  assign balls        = balls_q;
  assign batting_team = bat_q;
  assign ball_drop    = drop_q;

endmodule

// File: tb/tb_innings_scorer.sv
// tb/tb_innings_scorer.sv - directed scoreboard bench for innings_scorer
module tb_innings_scorer;

  localparam int MB = 20;
  localparam int MW = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ball_valid = 1'b0;
  logic [3:0]  ball_code = 4'd0;
  logic        inningOver = 1'b0;
  logic        gameOver = 1'b0;
  logic [11:0] team1Data, team2Data;
  logic [7:0]  team1Balls, team2Balls, balls;
  logic        batting_team, ball_drop;

  logic        s_valid = 1'b0;
  logic [3:0]  s_code = 4'd0;
  logic        s_zero = 1'b0;
  logic [11:0] s_t1d, s_t2d;
  logic [7:0]  s_t1b, s_t2b, s_balls;
  logic        s_bt, s_drop;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [11:0] t1d;
    logic [11:0] t2d;
    logic [7:0]  t1b;
    logic [7:0]  t2b;
    logic [7:0]  b;
    logic        bt;
    logic        drop;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state: 0 TEAM1, 1 BREAK, 2 TEAM2, 3 DONE
  int m_st, m_r1, m_w1, m_b1, m_r2, m_w2, m_b2, m_bt;

  always #5 clk = ~clk;

  innings_scorer #(.MAX_BALLS(MB), .MAX_WICKETS(MW)) dut (
    .clk_fpga(clk), .reset(rst), .ball_valid(ball_valid), .ball_code(ball_code),
    .inningOver(inningOver), .gameOver(gameOver),
    .team1Data(team1Data), .team2Data(team2Data), .team1Balls(team1Balls),
    .team2Balls(team2Balls), .balls(balls), .batting_team(batting_team), .ball_drop(ball_drop)
  );

  innings_scorer #(.MAX_BALLS(64), .MAX_WICKETS(MW)) dut_sat (
    .clk_fpga(clk), .reset(rst), .ball_valid(s_valid), .ball_code(s_code),
    .inningOver(s_zero), .gameOver(s_zero),
    .team1Data(s_t1d), .team2Data(s_t2d), .team1Balls(s_t1b),
    .team2Balls(s_t2b), .balls(s_balls), .batting_team(s_bt), .ball_drop(s_drop)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_r1 = 0; m_w1 = 0; m_b1 = 0; m_r2 = 0; m_w2 = 0; m_b2 = 0; m_bt = 0;
    sb_q.delete();
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_t1data"}, team1Data, 0);
    chk({pfx, "_t2data"}, team2Data, 0);
    chk({pfx, "_t1balls"}, team1Balls, 0);
    chk({pfx, "_t2balls"}, team2Balls, 0);
    chk({pfx, "_balls"}, balls, 0);
    chk({pfx, "_bt"}, batting_team, 0);
    chk({pfx, "_drop"}, ball_drop, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ball_valid = 1'b0; ball_code = 4'd0; inningOver = 1'b0; gameOver = 1'b0;
    #1;
    check_all_zero("rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic step(input logic v, input logic [3:0] c, input logic io, input logic go);
    exp_t e;
    int   locked;
    int   inc;
    int   ns;
    bit   acc;
    @(negedge clk);
    ball_valid = v; ball_code = c; inningOver = io; gameOver = go;
    if (m_st == 0)      locked = (m_w1 >= MW || m_b1 >= MB) ? 1 : 0;
    else if (m_st == 2) locked = (m_w2 >= MW || m_b2 >= MB) ? 1 : 0;
    else                locked = 1;
    acc = v && (c < 10) && (locked == 0);
    inc = (c <= 6) ? int'(c) : ((c == 8 || c == 9) ? 1 : 0);
    if (acc) begin
      if (m_st == 0) begin
        m_r1 = (m_r1 + inc > 255) ? 255 : m_r1 + inc;
        if (c <= 7) m_b1++;
        if (c == 7) m_w1++;
      end else begin
        m_r2 = (m_r2 + inc > 255) ? 255 : m_r2 + inc;
        if (c <= 7) m_b2++;
        if (c == 7) m_w2++;
      end
    end
    ns = m_st;
    case (m_st)
      0: ns = go ? 3 : (io ? 1 : 0);
      1: begin ns = go ? 3 : 2; m_bt = 1; end
      2: ns = go ? 3 : 2;
      default: ns = 3;
    endcase
    m_st = ns;
    e.t1d  = 12'((m_r1 << 4) | m_w1);
    e.t2d  = 12'((m_r2 << 4) | m_w2);
    e.t1b  = 8'(m_b1);
    e.t2b  = 8'(m_b2);
    e.b    = (ns == 0) ? 8'(m_b1) : ((ns == 2) ? 8'(m_b2) : 8'd0);
    e.bt   = m_bt[0];
    e.drop = v && !acc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("t1data", team1Data, e.t1d);
    chk("t2data", team2Data, e.t2d);
    chk("t1balls", team1Balls, e.t1b);
    chk("t2balls", team2Balls, e.t2b);
    chk("balls", balls, e.b);
    chk("bt", batting_team, e.bt);
    chk("drop", ball_drop, e.drop);
  endtask

  initial begin
    model_reset();
    do_reset();

    // Basic scoring: 4 + 6 + wide + 1 = 12 runs, 3 legal balls
    step(1, 4'd4, 0, 0); step(1, 4'd6, 0, 0); step(1, 4'd8, 0, 0); step(1, 4'd1, 0, 0);
    step(0, 4'd0, 0, 0);
    chk("basic_runs", team1Data[11:4], 12);
    chk("basic_wkts", team1Data[3:0], 0);
    chk("basic_t1balls", team1Balls, 3);
    chk("basic_balls", balls, 3);

    // Illegal code is dropped, then drop clears
    step(1, 4'd12, 0, 0);
    step(0, 4'd0, 0, 0);
    chk("illegal_runs", team1Data[11:4], 12);

    // Wicket lock before inningOver
    do_reset();
    repeat (5) step(1, 4'd7, 0, 0);
    step(1, 4'd4, 0, 0);
    step(0, 4'd0, 0, 0);
    chk("lock_t1data", team1Data, {8'd0, 4'd5});
    chk("lock_t1balls", team1Balls, 5);

    // inningOver, strobe in BREAK dropped, team 2 starts
    step(0, 4'd0, 1, 0);
    step(1, 4'd2, 1, 0);
    step(1, 4'd3, 0, 0);
    chk("t2_first_runs", team2Data[11:4], 3);
    chk("t2_first_balls", team2Balls, 1);
    chk("t2_bt", batting_team, 1);
    chk("t2_t1_frozen", team1Data, {8'd0, 4'd5});

    // Fill team 2 to the ball limit, then a no-ball is dropped
    for (int i = 0; i < 19; i++) begin
      if (i == 5) step(1, 4'd8, 0, 0);
      step(1, 4'(i % 7), 0, 0);
    end
    step(1, 4'd9, 0, 0);
    chk("t2_ball_limit", team2Balls, 20);
    step(0, 4'd0, 0, 1);
    chk("done_balls", balls, 0);
    step(1, 4'd1, 0, 0);
    step(1, 4'd7, 0, 0);
    step(0, 4'd0, 0, 0);

    // Ball with inningOver applies; then async reset mid-TEAM2
    do_reset();
    step(1, 4'd5, 0, 0);
    step(1, 4'd2, 1, 0);
    step(0, 4'd0, 0, 0);
    step(1, 4'd4, 0, 0);
    step(1, 4'd9, 0, 0);
    chk("pre_async_t2runs", team2Data[11:4], 5);
    #2;
    rst = 1'b1;
    ball_valid = 1'b0; ball_code = 4'd0; inningOver = 1'b0; gameOver = 1'b0;
    #1;
    check_all_zero("async");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(1, 4'd3, 0, 0);
    chk("resume_runs", team1Data[11:4], 3);
    chk("resume_bt", batting_team, 0);

    // gameOver directly from TEAM1, and priority over inningOver
    step(1, 4'd1, 1, 1);
    step(1, 4'd1, 0, 0);

    // gameOver during BREAK
    do_reset();
    step(0, 4'd0, 1, 0);
    step(0, 4'd0, 0, 1);
    step(1, 4'd2, 0, 0);

    // Ball with gameOver in TEAM2 is applied
    do_reset();
    step(0, 4'd0, 1, 0);
    step(0, 4'd0, 0, 0);
    step(1, 4'd6, 0, 1);
    chk("go_ball_t2runs", team2Data[11:4], 6);
    step(1, 4'd6, 0, 0);
    step(0, 4'd0, 0, 0);

    // Run saturation on the wide-ball-limit instance
    do_reset();
    for (int i = 1; i <= 43; i++) begin
      @(negedge clk);
      s_valid = 1'b1; s_code = 4'd6;
      @(posedge clk);
      #1;
      chk("sat_runs", s_t1d[11:4], (6 * i > 255) ? 255 : 6 * i);
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("sat_balls", s_t1b, 43);
    chk("sat_drop", s_drop, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
